// File: rtl/vga_timing_pkg.sv
// Shared defaults and helpers for the raster timing generator.
package vga_timing_pkg;

    // 640x480 at 60 Hz
    localparam int unsigned DEF_HACT  = 640;
    localparam int unsigned DEF_HFP   = 16;
    localparam int unsigned DEF_HSW   = 96;
    localparam int unsigned DEF_HBP   = 48;
    localparam int unsigned DEF_VACT  = 480;
    localparam int unsigned DEF_VFP   = 10;
    localparam int unsigned DEF_VSW   = 2;
    localparam int unsigned DEF_VBP   = 33;
    localparam int unsigned DEF_COLOR_W = 8;
    localparam int unsigned DEF_NUM_CH  = 3;
    localparam int unsigned DEF_CNT_W   = 12;

    // Total period of one axis (line in pixels or frame in lines).
    function automatic int unsigned calc_total(input int unsigned act, input int unsigned fp,
                                               input int unsigned sw, input int unsigned bp);
        return act + fp + sw + bp;
    endfunction

    // First count inside the sync window (region order is ACT, FP, SW, BP).
    function automatic int unsigned sync_start(input int unsigned act, input int unsigned fp);
        return act + fp;
    endfunction

    // First count after the sync window.
    function automatic int unsigned sync_end(input int unsigned act, input int unsigned fp,
                                             input int unsigned sw);
        return act + fp + sw;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-(MAX+1) position counter for one raster axis, with synchronous clear.
module vga_axis_counter #(
    parameter int unsigned MAX = 799,
    parameter int unsigned W   = 12
) (
    input  logic         pix_clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = inc && (cnt == W'(MAX));

    // Count on inc, roll over at MAX; clear has priority over counting.
    always_ff @(posedge pix_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen_param.sv
// Raster timing generator: h/v counters, sync/active windows and a registered output stage.
module vga_timing_gen_param
    import vga_timing_pkg::*;
#(
    parameter int unsigned HACT      = DEF_HACT,
    parameter int unsigned HFP       = DEF_HFP,
    parameter int unsigned HSW       = DEF_HSW,
    parameter int unsigned HBP       = DEF_HBP,
    parameter int unsigned VACT      = DEF_VACT,
    parameter int unsigned VFP       = DEF_VFP,
    parameter int unsigned VSW       = DEF_VSW,
    parameter int unsigned VBP       = DEF_VBP,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned COLOR_W   = DEF_COLOR_W,
    parameter int unsigned NUM_CH    = DEF_NUM_CH,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic                      pix_clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      restart,
    input  logic [NUM_CH*COLOR_W-1:0] pixel_in,
    output logic                      pixel_req,
    output logic [CNT_W-1:0]          x_pos,
    output logic [CNT_W-1:0]          y_pos,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      de,
    output logic [NUM_CH*COLOR_W-1:0] pixel_out,
    output logic                      line_start,
    output logic                      frame_start
);

    localparam int unsigned HTOTAL = calc_total(HACT, HFP, HSW, HBP);
    localparam int unsigned VTOTAL = calc_total(VACT, VFP, VSW, VBP);

    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(HACT);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(VACT);
    localparam logic [CNT_W-1:0] HS_START  = CNT_W'(sync_start(HACT, HFP));
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(sync_end(HACT, HFP, HSW));
    localparam logic [CNT_W-1:0] VS_START  = CNT_W'(sync_start(VACT, VFP));
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(sync_end(VACT, VFP, VSW));

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_inc;
    logic             v_wrap_unused;

    logic active;
    logic h_in_sync;
    logic v_in_sync;
    logic h_first;
    logic v_first;

    assign v_inc = enable & h_wrap;

    vga_axis_counter #(
        .MAX (HTOTAL - 1),
        .W   (CNT_W)
    ) u_h_cnt (
        .pix_clk (pix_clk),
        .reset_n (reset_n),
        .inc     (enable),
        .clr     (restart),
        .cnt     (h_cnt),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(
        .MAX (VTOTAL - 1),
        .W   (CNT_W)
    ) u_v_cnt (
        .pix_clk (pix_clk),
        .reset_n (reset_n),
        .inc     (v_inc),
        .clr     (restart),
        .cnt     (v_cnt),
        .wrap    (v_wrap_unused)
    );

    // Window decode of the current counter position.
    always_comb begin
        active    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        h_in_sync = (h_cnt >= HS_START) && (h_cnt < HS_END);
        v_in_sync = (v_cnt >= VS_START) && (v_cnt < VS_END);
        h_first   = (h_cnt == '0);
        v_first   = (v_cnt == '0);
        pixel_req = active & enable;
    end

    assign x_pos = h_cnt;
    assign y_pos = v_cnt;

    // Output stage: everything here reflects the counter state one cycle earlier.
    // Syncs only update while enabled so a pause holds their level.
    always_ff @(posedge pix_clk or negedge reset_n) begin
        if (!reset_n) begin
            de          <= 1'b0;
            pixel_out   <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
        end else begin
            de          <= pixel_req;
            pixel_out   <= pixel_req ? pixel_in : '0;
            line_start  <= enable & h_first;
            frame_start <= enable & h_first & v_first;
            if (enable) begin
                hsync <= h_in_sync ^ ~HSYNC_POL;
                vsync <= v_in_sync ^ ~VSYNC_POL;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// Bench for vga_timing_gen_param: default 640x480 instance plus a tiny high-active-hsync instance.
module tb_vga_timing_gen_param;

    logic pix_clk = 1'b0;
    always #5 pix_clk = ~pix_clk;

    logic        reset_n;
    logic        enable;
    logic        restart;
    logic [23:0] pixel_in_a;
    logic [3:0]  pixel_in_b;

    logic        pixel_req_a, hsync_a, vsync_a, de_a, ls_a, fs_a;
    logic [11:0] x_a, y_a;
    logic [23:0] pixel_out_a;

    logic        pixel_req_b, hsync_b, vsync_b, de_b, ls_b, fs_b;
    logic [5:0]  x_b, y_b;
    logic [3:0]  pixel_out_b;

    vga_timing_gen_param u_dut_a (
        .pix_clk     (pix_clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .restart     (restart),
        .pixel_in    (pixel_in_a),
        .pixel_req   (pixel_req_a),
        .x_pos       (x_a),
        .y_pos       (y_a),
        .hsync       (hsync_a),
        .vsync       (vsync_a),
        .de          (de_a),
        .pixel_out   (pixel_out_a),
        .line_start  (ls_a),
        .frame_start (fs_a)
    );

    // Tiny raster: line 15 pixels (8 act, sync at 10..12), frame 8 lines (4 act, sync at 5..6).
    vga_timing_gen_param #(
        .HACT(8), .HFP(2), .HSW(3), .HBP(2),
        .VACT(4), .VFP(1), .VSW(2), .VBP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0),
        .COLOR_W(4), .NUM_CH(1), .CNT_W(6)
    ) u_dut_b (
        .pix_clk     (pix_clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .restart     (restart),
        .pixel_in    (pixel_in_b),
        .pixel_req   (pixel_req_b),
        .x_pos       (x_b),
        .y_pos       (y_b),
        .hsync       (hsync_b),
        .vsync       (vsync_b),
        .de          (de_b),
        .pixel_out   (pixel_out_b),
        .line_start  (ls_b),
        .frame_start (fs_b)
    );

    typedef struct packed {
        logic        de;
        logic [23:0] pix;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic [11:0] x;
        logic [11:0] y;
    } obs_t;

    typedef struct {
        int h;
        int v;
        bit hs;
        bit vs;
    } model_t;

    model_t ma, mb;
    obs_t   qa[$];
    obs_t   qb[$];
    obs_t   ea, eb, oa, ob;

    int n_vec = 0;
    int n_bad = 0;

    // Reference raster model: expected outputs after the next edge, then advance.
    task automatic model_step(inout model_t m, input bit en, input bit rs,
                              input int ht, input int vt, input int hact, input int vact,
                              input int hlo, input int hhi, input int vlo, input int vhi,
                              input bit hpol, input bit vpol, input logic [23:0] pix,
                              output obs_t e);
        bit req;
        req   = en && (m.h < hact) && (m.v < vact);
        e.de  = req;
        e.pix = req ? pix : 24'd0;
        if (en) begin
            m.hs = (m.h >= hlo && m.h < hhi) ? hpol : !hpol;
            m.vs = (m.v >= vlo && m.v < vhi) ? vpol : !vpol;
        end
        e.hs = m.hs;
        e.vs = m.vs;
        e.ls = en && (m.h == 0);
        e.fs = en && (m.h == 0) && (m.v == 0);
        if (rs) begin
            m.h = 0;
            m.v = 0;
        end else if (en) begin
            if (m.h == ht - 1) begin
                m.h = 0;
                m.v = (m.v == vt - 1) ? 0 : m.v + 1;
            end else begin
                m.h = m.h + 1;
            end
        end
        e.x = 12'(m.h);
        e.y = 12'(m.v);
    endtask

    // Apply one cycle of stimulus to both instances and queue what each must show.
    task automatic drive(input bit en, input bit rs);
        obs_t e;
        enable     = en;
        restart    = rs;
        pixel_in_a = {3{8'(ma.h)}};
        pixel_in_b = 4'(mb.h);
        model_step(ma, en, rs, 800, 525, 640, 480, 656, 752, 490, 492, 1'b0, 1'b0, pixel_in_a, e);
        qa.push_back(e);
        model_step(mb, en, rs, 15, 8, 8, 4, 10, 13, 5, 7, 1'b1, 1'b0, {20'd0, pixel_in_b}, e);
        qb.push_back(e);
        @(posedge pix_clk);
        @(negedge pix_clk);
    endtask

    task automatic model_reset();
        ma = '{h: 0, v: 0, hs: 1'b1, vs: 1'b1};
        mb = '{h: 0, v: 0, hs: 1'b0, vs: 1'b1};
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        enable     = 1'b0;
        restart    = 1'b1;
        pixel_in_a = '0;
        pixel_in_b = '0;
        repeat (3) @(negedge pix_clk);
        n_vec++;
        if (x_a !== 12'd0 || y_a !== 12'd0) begin
            n_bad++; $display("FAIL reset_pos_a got x=%0d y=%0d exp 0 0", x_a, y_a);
        end
        n_vec++;
        if (de_a !== 1'b0 || pixel_out_a !== 24'd0 || ls_a !== 1'b0 || fs_a !== 1'b0 || pixel_req_a !== 1'b0) begin
            n_bad++; $display("FAIL reset_out_a got de=%b pix=%h ls=%b fs=%b req=%b exp all 0",
                              de_a, pixel_out_a, ls_a, fs_a, pixel_req_a);
        end
        n_vec++;
        if (hsync_a !== 1'b1 || vsync_a !== 1'b1) begin
            n_bad++; $display("FAIL reset_sync_a got hs=%b vs=%b exp 1 1", hsync_a, vsync_a);
        end
        n_vec++;
        if (hsync_b !== 1'b0 || vsync_b !== 1'b1 || x_b !== 6'd0 || y_b !== 6'd0) begin
            n_bad++; $display("FAIL reset_b got hs=%b vs=%b x=%0d y=%0d exp 0 1 0 0", hsync_b, vsync_b, x_b, y_b);
        end
        restart = 1'b0;
    endtask

    task automatic test_startup();
        enable  = 1'b1;
        restart = 1'b0;
        reset_n = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (x_a !== 12'd0 || y_a !== 12'd0 || de_a !== 1'b0 || pixel_req_a !== 1'b1) begin
            n_bad++; $display("FAIL startup_first got x=%0d y=%0d de=%b req=%b exp 0 0 0 1", x_a, y_a, de_a, pixel_req_a);
        end
        drive(1'b1, 1'b0);
        ea = qa.pop_front(); eb = qb.pop_front();
        oa = {de_a, pixel_out_a, hsync_a, vsync_a, ls_a, fs_a, x_a, y_a};
        ob = {de_b, 20'd0, pixel_out_b, hsync_b, vsync_b, ls_b, fs_b, 6'd0, x_b, 6'd0, y_b};
        n_vec++; if (oa !== ea) begin n_bad++; $display("FAIL startup_sb_a got %h exp %h", oa, ea); end
        n_vec++; if (ob !== eb) begin n_bad++; $display("FAIL startup_sb_b got %h exp %h", ob, eb); end
        n_vec++;
        if (fs_a !== 1'b1 || ls_a !== 1'b1 || de_a !== 1'b1 || x_a !== 12'd1) begin
            n_bad++; $display("FAIL startup_second got fs=%b ls=%b de=%b x=%0d exp 1 1 1 1", fs_a, ls_a, de_a, x_a);
        end
    endtask

    task automatic test_line();
        int hs_low = 0, de_hi = 0, ls_first = -1, ls_second = -1, hprev;
        logic last_hs;
        last_hs = hsync_a;
        for (int i = 0; i < 1600; i++) begin
            hprev = ma.h;
            drive(1'b1, 1'b0);
            ea = qa.pop_front(); eb = qb.pop_front();
            oa = {de_a, pixel_out_a, hsync_a, vsync_a, ls_a, fs_a, x_a, y_a};
            ob = {de_b, 20'd0, pixel_out_b, hsync_b, vsync_b, ls_b, fs_b, 6'd0, x_b, 6'd0, y_b};
            n_vec++; if (oa !== ea) begin n_bad++; $display("FAIL line_sb_a i=%0d got %h exp %h", i, oa, ea); end
            n_vec++; if (ob !== eb) begin n_bad++; $display("FAIL line_sb_b i=%0d got %h exp %h", i, ob, eb); end
            if (i < 800) begin
                if (hsync_a === 1'b0) hs_low++;
                if (de_a === 1'b1) de_hi++;
            end
            if (ls_a === 1'b1) begin
                if (ls_first < 0) ls_first = i;
                else if (ls_second < 0) ls_second = i;
            end
            if (hsync_a === 1'b0 && last_hs === 1'b1) begin
                n_vec++;
                if (hprev != 656) begin
                    n_bad++; $display("FAIL hsync_fall_pos got h=%0d exp 656", hprev);
                end
            end
            last_hs = hsync_a;
        end
        n_vec++; if (hs_low != 96) begin n_bad++; $display("FAIL hsync_low_len got %0d exp 96", hs_low); end
        n_vec++; if (de_hi != 640) begin n_bad++; $display("FAIL de_per_line got %0d exp 640", de_hi); end
        n_vec++;
        if (ls_second - ls_first != 800) begin
            n_bad++; $display("FAIL line_period got %0d exp 800", ls_second - ls_first);
        end
    endtask

    task automatic test_enable_hold();
        int guard = 0;
        int cnt;
        while (!(ma.h == 100 && ma.v == 5) && guard < 5000) begin
            drive(1'b1, 1'b0);
            ea = qa.pop_front(); eb = qb.pop_front();
            oa = {de_a, pixel_out_a, hsync_a, vsync_a, ls_a, fs_a, x_a, y_a};
            ob = {de_b, 20'd0, pixel_out_b, hsync_b, vsync_b, ls_b, fs_b, 6'd0, x_b, 6'd0, y_b};
            n_vec++; if (oa !== ea) begin n_bad++; $display("FAIL seek_sb_a got %h exp %h", oa, ea); end
            n_vec++; if (ob !== eb) begin n_bad++; $display("FAIL seek_sb_b got %h exp %h", ob, eb); end
            guard++;
        end
        n_vec++; if (guard >= 5000) begin n_bad++; $display("FAIL hold_seek_timeout got %0d cycles exp <5000", guard); end
        for (int i = 0; i < 37; i++) begin
            drive(1'b0, 1'b0);
            ea = qa.pop_front(); eb = qb.pop_front();
            oa = {de_a, pixel_out_a, hsync_a, vsync_a, ls_a, fs_a, x_a, y_a};
            ob = {de_b, 20'd0, pixel_out_b, hsync_b, vsync_b, ls_b, fs_b, 6'd0, x_b, 6'd0, y_b};
            n_vec++; if (oa !== ea) begin n_bad++; $display("FAIL hold_sb_a got %h exp %h", oa, ea); end
            n_vec++; if (ob !== eb) begin n_bad++; $display("FAIL hold_sb_b got %h exp %h", ob, eb); end
            n_vec++;
            if (x_a !== 12'd100 || y_a !== 12'd5 || de_a !== 1'b0 || pixel_req_a !== 1'b0 || pixel_req_b !== 1'b0) begin
                n_bad++; $display("FAIL hold_a got x=%0d y=%0d de=%b req=%b/%b exp 100 5 0 0/0",
                                  x_a, y_a, de_a, pixel_req_a, pixel_req_b);
            end
        end
        drive(1'b1, 1'b0);
        ea = qa.pop_front(); eb = qb.pop_front();
        oa = {de_a, pixel_out_a, hsync_a, vsync_a, ls_a, fs_a, x_a, y_a};
        ob = {de_b, 20'd0, pixel_out_b, hsync_b, vsync_b, ls_b, fs_b, 6'd0, x_b, 6'd0, y_b};
        n_vec++; if (oa !== ea) begin n_bad++; $display("FAIL resume_sb_a got %h exp %h", oa, ea); end
        n_vec++; if (ob !== eb) begin n_bad++; $display("FAIL resume_sb_b got %h exp %h", ob, eb); end
        n_vec++;
        if (de_a !== 1'b1 || pixel_out_a !== {3{8'd100}}) begin
            n_bad++; $display("FAIL resume_pixel got de=%b pix=%h exp 1 646464", de_a, pixel_out_a);
        end
        cnt = 1;
        while (x_a !== 12'd100 && cnt < 1000) begin
            drive(1'b1, 1'b0);
            ea = qa.pop_front(); eb = qb.pop_front();
            oa = {de_a, pixel_out_a, hsync_a, vsync_a, ls_a, fs_a, x_a, y_a};
            ob = {de_b, 20'd0, pixel_out_b, hsync_b, vsync_b, ls_b, fs_b, 6'd0, x_b, 6'd0, y_b};
            n_vec++; if (oa !== ea) begin n_bad++; $display("FAIL resume_line_sb_a got %h exp %h", oa, ea); end
            n_vec++; if (ob !== eb) begin n_bad++; $display("FAIL resume_line_sb_b got %h exp %h", ob, eb); end
            cnt++;
        end
        n_vec++; if (cnt != 800) begin n_bad++; $display("FAIL resume_line_len got %0d exp 800", cnt); end
    endtask

    task automatic test_frame_b();
        int guard = 0, vs_low = 0, de_hi = 0, hs_hi = 0, fs_first = -1, fs_second = -1, hprev, vprev;
        logic last_vs;
        while (!(mb.h == 0 && mb.v == 0) && guard < 200) begin
            drive(1'b1, 1'b0);
            ea = qa.pop_front(); eb = qb.pop_front();
            oa = {de_a, pixel_out_a, hsync_a, vsync_a, ls_a, fs_a, x_a, y_a};
            ob = {de_b, 20'd0, pixel_out_b, hsync_b, vsync_b, ls_b, fs_b, 6'd0, x_b, 6'd0, y_b};
            n_vec++; if (oa !== ea) begin n_bad++; $display("FAIL frame_seek_sb_a got %h exp %h", oa, ea); end
            n_vec++; if (ob !== eb) begin n_bad++; $display("FAIL frame_seek_sb_b got %h exp %h", ob, eb); end
            guard++;
        end
        n_vec++; if (guard >= 200) begin n_bad++; $display("FAIL frame_seek_timeout got %0d cycles exp <200", guard); end
        last_vs = vsync_b;
        for (int i = 0; i < 240; i++) begin
            hprev = mb.h;
            vprev = mb.v;
            drive(1'b1, 1'b0);
            ea = qa.pop_front(); eb = qb.pop_front();
            oa = {de_a, pixel_out_a, hsync_a, vsync_a, ls_a, fs_a, x_a, y_a};
            ob = {de_b, 20'd0, pixel_out_b, hsync_b, vsync_b, ls_b, fs_b, 6'd0, x_b, 6'd0, y_b};
            n_vec++; if (oa !== ea) begin n_bad++; $display("FAIL frame_sb_a got %h exp %h", oa, ea); end
            n_vec++; if (ob !== eb) begin n_bad++; $display("FAIL frame_sb_b got %h exp %h", ob, eb); end
            if (vsync_b === 1'b0) vs_low++;
            if (de_b === 1'b1) de_hi++;
            if (hsync_b === 1'b1) hs_hi++;
            if (fs_b === 1'b1) begin
                if (fs_first < 0) fs_first = i;
                else if (fs_second < 0) fs_second = i;
            end
            if (vsync_b === 1'b0 && last_vs === 1'b1) begin
                n_vec++;
                if (hprev != 0 || vprev != 5) begin
                    n_bad++; $display("FAIL vsync_fall_pos got h=%0d v=%0d exp 0 5", hprev, vprev);
                end
            end
            last_vs = vsync_b;
        end
        n_vec++; if (vs_low != 60) begin n_bad++; $display("FAIL vsync_low_len got %0d exp 60", vs_low); end
        n_vec++; if (de_hi != 64) begin n_bad++; $display("FAIL de_per_frame got %0d exp 64", de_hi); end
        n_vec++; if (hs_hi != 48) begin n_bad++; $display("FAIL hsync_high_pol got %0d exp 48", hs_hi); end
        n_vec++;
        if (fs_second - fs_first != 120) begin
            n_bad++; $display("FAIL frame_period got %0d exp 120", fs_second - fs_first);
        end
    endtask

    task automatic test_restart();
        int guard = 0;
        while (ma.h != 700 && guard < 900) begin
            drive(1'b1, 1'b0);
            ea = qa.pop_front(); eb = qb.pop_front();
            oa = {de_a, pixel_out_a, hsync_a, vsync_a, ls_a, fs_a, x_a, y_a};
            ob = {de_b, 20'd0, pixel_out_b, hsync_b, vsync_b, ls_b, fs_b, 6'd0, x_b, 6'd0, y_b};
            n_vec++; if (oa !== ea) begin n_bad++; $display("FAIL rs_seek_sb_a got %h exp %h", oa, ea); end
            n_vec++; if (ob !== eb) begin n_bad++; $display("FAIL rs_seek_sb_b got %h exp %h", ob, eb); end
            guard++;
        end
        n_vec++; if (guard >= 900) begin n_bad++; $display("FAIL restart_seek_timeout got %0d exp <900", guard); end
        for (int step = 0; step < 6; step++) begin
            bit en, rs;
            // steps: restart, run, run x2, restart while paused, stay paused, resume
            en = (step != 3 && step != 4);
            rs = (step == 0 || step == 3);
            drive(en, rs);
            ea = qa.pop_front(); eb = qb.pop_front();
            oa = {de_a, pixel_out_a, hsync_a, vsync_a, ls_a, fs_a, x_a, y_a};
            ob = {de_b, 20'd0, pixel_out_b, hsync_b, vsync_b, ls_b, fs_b, 6'd0, x_b, 6'd0, y_b};
            n_vec++; if (oa !== ea) begin n_bad++; $display("FAIL restart_sb_a s=%0d got %h exp %h", step, oa, ea); end
            n_vec++; if (ob !== eb) begin n_bad++; $display("FAIL restart_sb_b s=%0d got %h exp %h", step, ob, eb); end
            if (step == 0 || step == 3 || step == 4) begin
                n_vec++;
                if (x_a !== 12'd0 || y_a !== 12'd0 || x_b !== 6'd0 || y_b !== 6'd0) begin
                    n_bad++; $display("FAIL restart_pos s=%0d got a=%0d,%0d b=%0d,%0d exp zeros", step, x_a, y_a, x_b, y_b);
                end
            end
            if (step == 1 || step == 5) begin
                n_vec++;
                if (fs_a !== 1'b1 || fs_b !== 1'b1) begin
                    n_bad++; $display("FAIL restart_fs s=%0d got %b/%b exp 1/1", step, fs_a, fs_b);
                end
            end
            if (step == 4) begin
                n_vec++;
                if (fs_a !== 1'b0 || ls_a !== 1'b0) begin
                    n_bad++; $display("FAIL paused_no_pulse got fs=%b ls=%b exp 0 0", fs_a, ls_a);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        repeat (20) begin
            drive(1'b1, 1'b0);
            ea = qa.pop_front(); eb = qb.pop_front();
            oa = {de_a, pixel_out_a, hsync_a, vsync_a, ls_a, fs_a, x_a, y_a};
            ob = {de_b, 20'd0, pixel_out_b, hsync_b, vsync_b, ls_b, fs_b, 6'd0, x_b, 6'd0, y_b};
            n_vec++; if (oa !== ea) begin n_bad++; $display("FAIL pre_areset_sb_a got %h exp %h", oa, ea); end
            n_vec++; if (ob !== eb) begin n_bad++; $display("FAIL pre_areset_sb_b got %h exp %h", ob, eb); end
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (x_a !== 12'd0 || y_a !== 12'd0 || de_a !== 1'b0 || pixel_out_a !== 24'd0 || hsync_a !== 1'b1) begin
            n_bad++; $display("FAIL async_reset_a got x=%0d y=%0d de=%b pix=%h hs=%b exp 0 0 0 0 1",
                              x_a, y_a, de_a, pixel_out_a, hsync_a);
        end
        n_vec++;
        if (x_b !== 6'd0 || hsync_b !== 1'b0 || vsync_b !== 1'b1) begin
            n_bad++; $display("FAIL async_reset_b got x=%0d hs=%b vs=%b exp 0 0 1", x_b, hsync_b, vsync_b);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_startup();
        test_line();
        test_enable_hold();
        test_frame_b();
        test_restart();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
